// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache/memory line arbiter: FSM states, grant source
// tags and default bus widths.
package arb_types;

    localparam int unsigned ARB_ADDR_WIDTH = 32;
    localparam int unsigned ARB_LINE_WIDTH = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_SERVE = 2'd1,
        D_SERVE = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

    function automatic logic arb_is_serve(input arb_state_t s);
        return (s == I_SERVE) || (s == D_SERVE);
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_req_latch.sv
// Request latch for the arbiter: captures the winning request's address,
// write data and operation on the grant strobe so the memory command stays
// stable while the requesters' inputs move.
module arb_req_latch #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_grant,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [LINE_WIDTH-1:0] i_wdata,
    input  logic                  i_write,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [LINE_WIDTH-1:0] o_wdata,
    output logic                  o_write
);

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic                  r_write;

    // Capture the granted request; hold it until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
        end else if (i_grant) begin
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_write <= i_write;
        end
    end

    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;
    assign o_write = r_write;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbiter sharing one physical-memory line port between the I-cache and
// D-cache miss paths. D has fixed priority; one whole-line transfer at a time,
// followed by a one-cycle response to the granted cache only.
// Optional: define ARB_STARVE_GUARD_EN to let a waiting I request win after
// STARVE_LIMIT consecutive D grants.
module cache_mem_arbiter
    import arb_types::*;
#(
    parameter int unsigned ADDR_WIDTH   = ARB_ADDR_WIDTH,
    parameter int unsigned LINE_WIDTH   = ARB_LINE_WIDTH,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    arb_src_t              r_src;
    logic [LINE_WIDTH-1:0] r_line;

    logic                  w_d_req;
    logic                  w_i_req;
    logic                  w_force_i;
    logic                  w_pick_d;
    logic                  w_grant;
    logic                  w_serve;
    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic [LINE_WIDTH-1:0] w_req_wdata;
    logic                  w_req_write;
    logic [ADDR_WIDTH-1:0] w_op_addr;
    logic [LINE_WIDTH-1:0] w_op_wdata;
    logic                  w_op_write;

    assign w_d_req = d_pmem_read | d_pmem_write;
    assign w_i_req = i_pmem_read;
    assign w_serve = arb_is_serve(r_state);
    assign w_grant = (r_state == IDLE) && (w_d_req || w_i_req);

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned STARVE_CW = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_CW-1:0] r_starve_cnt;

    assign w_force_i = (r_starve_cnt >= STARVE_CW'(STARVE_LIMIT));

    // Count consecutive D grants taken while I was waiting in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (!w_i_req) begin
                r_starve_cnt <= '0;
            end else if (w_grant && !w_pick_d) begin
                r_starve_cnt <= '0;
            end else if (w_grant && !w_force_i) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end
`else
    assign w_force_i = 1'b0;
`endif

    // D wins a simultaneous request unless the starvation guard forces I.
    assign w_pick_d = w_d_req && !(w_force_i && w_i_req);

    // Mux the winning request into the latch; a write overrides a read.
    always_comb begin
        w_req_addr  = i_pmem_address;
        w_req_wdata = '0;
        w_req_write = 1'b0;
        if (w_pick_d) begin
            w_req_addr  = d_pmem_address;
            w_req_wdata = d_pmem_wdata;
            w_req_write = d_pmem_write;
        end
    end

    arb_req_latch #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LINE_WIDTH (LINE_WIDTH)
    ) u_req_latch (
        .clk     (clk),
        .rst     (rst),
        .i_grant (w_grant),
        .i_addr  (w_req_addr),
        .i_wdata (w_req_wdata),
        .i_write (w_req_write),
        .o_addr  (w_op_addr),
        .o_wdata (w_op_wdata),
        .o_write (w_op_write)
    );

    // Next-state logic: IDLE -> SERVE on grant, SERVE -> DONE on mem_resp,
    // DONE always returns to IDLE after one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_state_nxt = w_pick_d ? D_SERVE : I_SERVE;
                end
            end
            I_SERVE, D_SERVE: begin
                if (mem_resp) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // On memory completion capture read data and record who was served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line <= '0;
            r_src  <= SRC_I;
        end else if (w_serve && mem_resp) begin
            if (!w_op_write) begin
                r_line <= mem_rdata;
            end
            r_src <= (r_state == D_SERVE) ? SRC_D : SRC_I;
        end
    end

    // Memory command comes only from the latch, qualified by the SERVE state,
    // so reset drops it asynchronously.
    assign mem_read    = w_serve && !w_op_write;
    assign mem_write   = w_serve && w_op_write;
    assign mem_address = w_op_addr;
    assign mem_wdata   = w_op_wdata;

    assign i_pmem_resp  = (r_state == DONE) && (r_src == SRC_I);
    assign d_pmem_resp  = (r_state == DONE) && (r_src == SRC_D);
    assign i_pmem_rdata = r_line;
    assign d_pmem_rdata = r_line;

`ifndef SYNTHESIS
    // Simultaneous D read and write is a requester protocol error.
    a_d_rw_conflict : assert property (@(posedge clk) disable iff (rst)
        !((r_state == IDLE) && d_pmem_read && d_pmem_write))
        else $error("cache_mem_arbiter: d_pmem_read and d_pmem_write both set, write wins");
`endif

endmodule
